btn_event_tx: RTL and testbench

- Consumes the debounced button front pulses and filtered levels produced by the button filter stage, one filter per button.
- Converts each press into a one-byte key code and buffers codes in a small FIFO.
- Presents the codes to the UART transmitter through a valid/ready handshake.
- Sits between the button filter bank and the UART TX path of the controller.

---
 rtl/btn_event_pkg.sv | 25 ++
 rtl/btn_event_tx_fifo.sv | 63 ++++++
 rtl/btn_event_tx.sv | 174 +++++++++++++++++
 tb/tb_btn_event_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared types and constants for the button event transmitter.
//   rep_state_t   - auto-repeat FSM states
//   FIFO_CNT_W    - width of the FIFO occupancy count
//   CODE_BASE_DEF - default key code for button 0
//   lowest_idx()  - index of the lowest set bit in an 8-bit vector
package btn_event_pkg;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_REPEAT = 2'd2
  } rep_state_t;

  localparam int         FIFO_CNT_W    = 5;
  localparam logic [7:0] CODE_BASE_DEF = 8'h41;

  // Returns 0 for an all-zero vector; callers gate on the vector being non-zero.
  function automatic logic [2:0] lowest_idx(input logic [7:0] vec);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/btn_event_tx_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Ports:
//   CLK, RST_N   - clock, async active-low reset
//   push, din    - write request and data; accepted when not full, or when
//                  a pop happens in the same cycle
//   pop          - read request; ignored while empty
//   dout         - data at the head (valid while !empty)
//   full, empty  - status
//   count        - occupancy, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the one being read out this cycle,
  // so a simultaneous pop frees it in time.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btn_event_tx.sv
// btn_event_tx: turns debounced button presses into key codes, queues them
// and hands them to the UART TX path over a valid/ready handshake.
// Ports:
//   CLK, RST_N         - clock, async active-low reset
//   CE                 - tick enable, drives the auto-repeat timer only
//   BTN_CEO[N_BTN]     - one-cycle press pulses from the filters
//   BTN_LVL[N_BTN]     - filtered button levels
//   TX_DATA, TX_VALID  - key code at the FIFO head / FIFO not empty
//   TX_READY           - UART accepts TX_DATA
//   OVF, OVF_CLR       - sticky dropped-event flag and its clear
//   FIFO_CNT           - FIFO occupancy
// Build option: define BTN_AUTO_REPEAT_EN to add the auto-repeat FSM;
// without it no repeat timer exists and CE/BTN_LVL are ignored.
//
// Auto-repeat FSM:
//   state      | meaning
//   REP_IDLE   | no button tracked
//   REP_DELAY  | tracked button held, waiting REP_DELAY ticks for first repeat
//   REP_REPEAT | tracked button held, repeating every REP_RATE ticks
module btn_event_tx
  import btn_event_pkg::*;
#(
  parameter int          N_BTN      = 4,
  parameter logic [7:0]  CODE_BASE  = CODE_BASE_DEF,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] REP_DELAY  = 16'd500,
  parameter logic [15:0] REP_RATE   = 16'd100
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CE,
  input  logic [N_BTN-1:0]      BTN_CEO,
  input  logic [N_BTN-1:0]      BTN_LVL,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  OVF,
  input  logic                  OVF_CLR,
  output logic [FIFO_CNT_W-1:0] FIFO_CNT
);

  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] served;
  logic [N_BTN-1:0] rep_pulse_vec;
  logic [2:0]       srv_idx;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       push_code;

  // Priority serializer: lowest pending index goes first, one code per cycle.
  assign srv_idx   = lowest_idx(8'(pend));
  assign push      = |pend;
  assign push_code = CODE_BASE + {5'd0, srv_idx};

  always_comb begin
    served = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (push && (srv_idx == 3'(i))) served[i] = 1'b1;
    end
  end

  // A served bit is cleared even when its code is dropped on a full FIFO.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pend <= '0;
    else        pend <= (pend & ~served) | BTN_CEO | rep_pulse_vec;
  end

  assign TX_VALID = ~fifo_empty;
  assign pop      = TX_VALID & TX_READY;
  assign drop     = push & fifo_full & ~pop;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(FIFO_CNT_W)
  ) u_fifo (
    .CLK  (CLK),
    .RST_N(RST_N),
    .push (push),
    .din  (push_code),
    .pop  (pop),
    .dout (TX_DATA),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(FIFO_CNT)
  );

  // Setting wins over a same-cycle clear so a drop is never lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       OVF <= 1'b0;
    else if (drop)    OVF <= 1'b1;
    else if (OVF_CLR) OVF <= 1'b0;
  end

`ifdef BTN_AUTO_REPEAT_EN
  rep_state_t  rep_state;
  rep_state_t  rep_state_nxt;
  logic [15:0] rep_cnt;
  logic [15:0] rep_cnt_nxt;
  logic [2:0]  rep_idx;
  logic [2:0]  rep_idx_nxt;
  logic [2:0]  ceo_idx;
  logic        trk_lvl;
  logic        rep_fire;

  assign ceo_idx = lowest_idx(8'(BTN_CEO));

  always_comb begin
    trk_lvl = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (rep_idx == 3'(i)) trk_lvl = BTN_LVL[i];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rep_state <= REP_IDLE;
      rep_cnt   <= '0;
      rep_idx   <= '0;
    end else begin
      rep_state <= rep_state_nxt;
      rep_cnt   <= rep_cnt_nxt;
      rep_idx   <= rep_idx_nxt;
    end
  end

  // A fresh press outranks release and counting; the terminal compare uses
  // <= 1 so a zero delay/rate still fires on the next tick instead of wrapping.
  always_comb begin
    rep_state_nxt = rep_state;
    rep_cnt_nxt   = rep_cnt;
    rep_idx_nxt   = rep_idx;
    rep_fire      = 1'b0;
    if (|BTN_CEO) begin
      rep_state_nxt = REP_DELAY;
      rep_cnt_nxt   = REP_DELAY;
      rep_idx_nxt   = ceo_idx;
    end else begin
      case (rep_state)
        REP_IDLE: rep_state_nxt = REP_IDLE;
        REP_DELAY, REP_REPEAT: begin
          if (!trk_lvl) begin
            rep_state_nxt = REP_IDLE;
          end else if (CE) begin
            if (rep_cnt <= 16'd1) begin
              rep_fire      = 1'b1;
              rep_state_nxt = REP_REPEAT;
              rep_cnt_nxt   = REP_RATE;
            end else begin
              rep_cnt_nxt = rep_cnt - 16'd1;
            end
          end
        end
        default: rep_state_nxt = REP_IDLE;
      endcase
    end
  end

  always_comb begin
    rep_pulse_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (rep_fire && (rep_idx == 3'(i))) rep_pulse_vec[i] = 1'b1;
    end
  end
`else
  logic unused_rep;
  assign unused_rep    = ^{CE, BTN_LVL, REP_DELAY, REP_RATE};
  assign rep_pulse_vec = '0;
`endif

endmodule

// File: tb/tb_btn_event_tx.sv
module tb_btn_event_tx;

  localparam int DEPTH = 4;
  localparam int RDLY  = 3;
  localparam int RRATE = 2;
  localparam int HOLD  = 10;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CE = 1'b1;
  logic [3:0] BTN_CEO = '0;
  logic [3:0] BTN_LVL = '0;
  logic       TX_READY = 1'b0;
  logic       OVF_CLR = 1'b0;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       OVF;
  logic [4:0] FIFO_CNT;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  btn_event_tx #(
    .N_BTN(4), .CODE_BASE(8'h41), .FIFO_DEPTH(DEPTH),
    .REP_DELAY(16'(RDLY)), .REP_RATE(16'(RRATE))
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .BTN_CEO(BTN_CEO), .BTN_LVL(BTN_LVL),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .OVF(OVF), .OVF_CLR(OVF_CLR), .FIFO_CNT(FIFO_CNT)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [3:0] ceo;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic [4:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] c, input logic r, input logic cl,
                     input logic v, input logic [7:0] d, input logic [4:0] n, input logic o);
    vec_t e;
    e.ceo = c; e.rdy = r; e.clr = cl; e.v = v; e.d = d; e.cnt = n; e.ovf = o;
    tbl.push_back(e);
  endtask

  // Reference model: pending set, queue of codes, sticky overflow flag.
  logic [7:0] mq[$];
  logic [3:0] m_pend;
  logic       m_ovf;

  task automatic model_edge();
    int  sz;
    int  idx;
    bit  popped;
    bit  dropped;
    sz      = mq.size();
    popped  = (sz != 0) && TX_READY;
    dropped = 1'b0;
    if (popped) void'(mq.pop_front());
    idx = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i]) idx = i;
    if (idx >= 0) begin
      if (sz < DEPTH || popped) mq.push_back(8'(65 + idx));
      else dropped = 1'b1;
      m_pend[idx] = 1'b0;
    end
    if (dropped) m_ovf = 1'b1;
    else if (OVF_CLR) m_ovf = 1'b0;
    m_pend = m_pend | BTN_CEO;
  endtask

  int exp_off[$];
  int got_off[$];

  initial begin
    // reset state
    #12;
    chk("rst_valid", TX_VALID, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_cnt", FIFO_CNT, 0);
    chk("rst_ovf", OVF, 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    step();

    //    ceo    rdy clr  v  data  cnt ovf
    add(4'b0001, 1, 0,   0, 8'h00, 0, 0);  // latency: visible two cycles later
    add(4'b0000, 1, 0,   1, 8'h41, 1, 0);
    add(4'b0000, 1, 0,   0, 8'h00, 0, 0);
    add(4'b1010, 1, 0,   0, 8'h00, 0, 0);  // two buttons, lowest first
    add(4'b0000, 1, 0,   1, 8'h42, 1, 0);
    add(4'b0000, 1, 0,   1, 8'h44, 1, 0);
    add(4'b0000, 1, 0,   0, 8'h00, 0, 0);
    add(4'b0100, 0, 0,   0, 8'h00, 0, 0);  // six presses of button 2, stalled
    add(4'b0100, 0, 0,   1, 8'h43, 1, 0);
    add(4'b0100, 0, 0,   1, 8'h43, 2, 0);
    add(4'b0100, 0, 0,   1, 8'h43, 3, 0);
    add(4'b0100, 0, 0,   1, 8'h43, 4, 0);
    add(4'b0100, 0, 0,   1, 8'h43, 4, 1);
    add(4'b0000, 0, 0,   1, 8'h43, 4, 1);
    add(4'b0000, 0, 0,   1, 8'h43, 4, 1);
    add(4'b0000, 0, 1,   1, 8'h43, 4, 0);  // clear overflow
    add(4'b0001, 0, 0,   1, 8'h43, 4, 0);  // full + push + pop together
    add(4'b0000, 1, 0,   1, 8'h43, 4, 0);
    add(4'b0000, 1, 0,   1, 8'h43, 3, 0);
    add(4'b0000, 1, 0,   1, 8'h43, 2, 0);
    add(4'b0000, 1, 0,   1, 8'h41, 1, 0);
    add(4'b0000, 1, 0,   0, 8'h00, 0, 0);
    add(4'b0011, 0, 0,   0, 8'h00, 0, 0);  // merge into a pending bit
    add(4'b0010, 0, 0,   1, 8'h41, 1, 0);
    add(4'b0000, 0, 0,   1, 8'h41, 2, 0);
    add(4'b0000, 0, 0,   1, 8'h41, 2, 0);
    add(4'b0000, 1, 0,   1, 8'h42, 1, 0);
    add(4'b0000, 1, 0,   0, 8'h00, 0, 0);
    add(4'b0001, 0, 0,   0, 8'h00, 0, 0);  // set beats same-cycle clear
    add(4'b0001, 0, 0,   1, 8'h41, 1, 0);
    add(4'b0001, 0, 0,   1, 8'h41, 2, 0);
    add(4'b0001, 0, 0,   1, 8'h41, 3, 0);
    add(4'b0001, 0, 0,   1, 8'h41, 4, 0);
    add(4'b0000, 0, 1,   1, 8'h41, 4, 1);
    add(4'b0000, 0, 1,   1, 8'h41, 4, 0);
    add(4'b0000, 1, 0,   1, 8'h41, 3, 0);
    add(4'b0000, 1, 0,   1, 8'h41, 2, 0);
    add(4'b0000, 1, 0,   1, 8'h41, 1, 0);
    add(4'b0000, 1, 0,   0, 8'h00, 0, 0);

    foreach (tbl[k]) begin
      BTN_CEO = tbl[k].ceo; TX_READY = tbl[k].rdy; OVF_CLR = tbl[k].clr;
      step();
      chk($sformatf("tbl%0d_valid", k), TX_VALID, tbl[k].v);
      chk($sformatf("tbl%0d_cnt", k), FIFO_CNT, tbl[k].cnt);
      chk($sformatf("tbl%0d_ovf", k), OVF, tbl[k].ovf);
      if (tbl[k].v) chk($sformatf("tbl%0d_data", k), TX_DATA, tbl[k].d);
    end
    BTN_CEO = '0; TX_READY = 1'b0; OVF_CLR = 1'b0;

    // reset in the middle of operation
    for (int n = 0; n < 4; n++) begin
      BTN_CEO = 4'b0001;
      step();
    end
    BTN_CEO = '0;
    chk("prerst_cnt", FIFO_CNT, 3);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_valid", TX_VALID, 0);
    chk("midrst_cnt", FIFO_CNT, 0);
    @(posedge CLK);
    #3 RST_N = 1'b1;
    TX_READY = 1'b1;
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("postrst%0d_valid", n), TX_VALID, 0);
      chk($sformatf("postrst%0d_cnt", n), FIFO_CNT, 0);
    end

    // auto-repeat: button 0 held HOLD cycles, press in cycle 0
    exp_off.push_back(2);
`ifdef BTN_AUTO_REPEAT_EN
    for (int p = RDLY; p <= HOLD - 1; p += RRATE) exp_off.push_back(p + 2);
`endif
    for (int n = 0; n < 30; n++) begin
      BTN_CEO = (n == 0) ? 4'b0001 : 4'b0000;
      BTN_LVL = (n < HOLD) ? 4'b0001 : 4'b0000;
      step();
      if (TX_VALID) begin
        got_off.push_back(n + 1);
        chk($sformatf("rep_data_at%0d", n + 1), TX_DATA, 8'h41);
      end
    end
    BTN_CEO = '0; BTN_LVL = '0;
    chk("rep_count", got_off.size(), exp_off.size());
    for (int i = 0; i < exp_off.size() && i < got_off.size(); i++)
      chk($sformatf("rep_offset%0d", i), got_off[i], exp_off[i]);

    // randomized traffic against the reference model
    #2 RST_N = 1'b0;
    @(posedge CLK);
    #3 RST_N = 1'b1;
    step();
    m_pend = '0; m_ovf = 1'b0;
    for (int n = 0; n < 400; n++) begin
      BTN_CEO  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      TX_READY = (n < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      OVF_CLR  = ($urandom_range(0, 11) == 0);
      model_edge();
      step();
      chk($sformatf("rnd%0d_valid", n), TX_VALID, mq.size() != 0);
      chk($sformatf("rnd%0d_cnt", n), FIFO_CNT, mq.size());
      chk($sformatf("rnd%0d_ovf", n), OVF, m_ovf);
      if (mq.size() != 0) chk($sformatf("rnd%0d_data", n), TX_DATA, mq[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
